mem_store_buffer: RTL

- Load/store front end placed directly upstream of the single-port data memory.
- Accepts memory requests from the execute stage over a valid/ready handshake and queues stores in a small in-order write buffer.
- Drains queued stores to the data memory one per cycle and serves loads with store-to-load forwarding from the buffer.
- Drives the memory's opcode/addr/datain inputs and consumes its combinational dataout.

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/sb_fifo.sv | 63 ++++++
 rtl/mem_store_buffer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared opcodes, FSM state and store-buffer entry type for the memory stage.
package mem_stage_pkg;

    localparam logic [5:0] OP_NOP   = 6'b000000;
    localparam logic [5:0] OP_LOAD  = 6'b010101;
    localparam logic [5:0] OP_STORE = 6'b010110;

    localparam int unsigned SB_ADDR_W = 6;
    localparam int unsigned SB_DATA_W = 32;

    typedef enum logic [0:0] {IDLE, LOAD_RD} ms_state_e;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// In-order circular store buffer; exposes every slot so the parent can search it.
module sb_fifo
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = sb_entry_t,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  entry_t             i_push_entry,
    input  logic               i_pop,
    output logic [CW-1:0]      o_count,
    output logic               o_full,
    output logic               o_empty,
    output logic [PW-1:0]      o_head,
    output entry_t             o_head_entry,
    output logic [DEPTH-1:0]   o_valid,
    output entry_t [DEPTH-1:0] o_entries
);

    entry_t [DEPTH-1:0] r_entries;
    logic [DEPTH-1:0]   r_valid;
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Pop before push so a push into the freed slot keeps its valid bit.
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (i_push) begin
                r_entries[r_tail] <= i_push_entry;
                r_valid[r_tail]   <= 1'b1;
                r_tail            <= r_tail + PW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_count      = r_count;
    assign o_full       = (r_count == CW'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_head       = r_head;
    assign o_head_entry = r_entries[r_head];
    assign o_valid      = r_valid;
    assign o_entries    = r_entries;

endmodule

// File: rtl/mem_store_buffer.sv
// Load/store front end: queues stores, drains one per cycle, forwards to loads.
module mem_store_buffer
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [5:0]             i_req_op,
    input  logic [ADDRESS_WIDTH:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0]  i_req_wdata,
    output logic                   o_resp_valid,
    output logic [DATA_WIDTH-1:0]  o_resp_rdata,
    output logic [5:0]             o_mem_opcode,
    output logic [ADDRESS_WIDTH:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0]  o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]  i_mem_rdata,
    output logic                   o_sb_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [ADDRESS_WIDTH:0]  addr;
        logic [DATA_WIDTH-1:0]   data;
    } entry_t;

    ms_state_e              r_state;
    logic [ADDRESS_WIDTH:0] r_ld_addr;
    logic                   r_resp_valid;
    logic [DATA_WIDTH-1:0]  r_resp_rdata;

    logic [CW-1:0]      w_count;
    logic               w_full;
    logic               w_empty;
    logic [PW-1:0]      w_head;
    entry_t             w_head_entry;
    logic [DEPTH-1:0]   w_valid;
    entry_t [DEPTH-1:0] w_entries;
    logic               w_accept;
    logic               w_push;
    logic               w_load;
    logic               w_drain;
    logic [PW-1:0]      w_idx;
    logic               w_fwd_hit;
    logic [DATA_WIDTH-1:0] w_fwd_data;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign o_req_ready = (r_state == IDLE) && !w_full;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_push      = w_accept && (i_req_op == OP_STORE);
    assign w_load      = w_accept && (i_req_op == OP_LOAD);
    // Reset gates the drain so no memory write happens on the reset edge.
    assign w_drain     = !rst && (r_state == IDLE) && !w_empty;

    sb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_sb_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry ('{addr: i_req_addr, data: i_req_wdata}),
        .i_pop        (w_drain),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head       (w_head),
        .o_head_entry (w_head_entry),
        .o_valid      (w_valid),
        .o_entries    (w_entries)
    );

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = w_head + PW'(k);
            if (w_valid[w_idx] && (w_entries[w_idx].addr == r_ld_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = w_entries[w_idx].data;
            end
        end
    end

    assign w_load_data = w_fwd_hit ? w_fwd_data : i_mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ld_addr    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_ld_addr <= i_req_addr;
                        r_state   <= LOAD_RD;
                    end
                end
                LOAD_RD: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_mem_opcode = OP_NOP;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        if (w_drain) begin
            o_mem_opcode = OP_STORE;
            o_mem_addr   = w_head_entry.addr;
            o_mem_wdata  = w_head_entry.data;
        end else if (!rst && (r_state == LOAD_RD)) begin
            o_mem_addr = r_ld_addr;
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_sb_empty   = (w_count == '0);

endmodule
